active_list: RTL and testbench



---
 rtl/mips_core_pkg.sv | 7 +
 rtl/active_list.sv | 116 +++++++++++
 tb/tb_active_list.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared types and constants for the out-of-order MIPS core
package mips_core_pkg;
  typedef logic [5:0] PhysReg;
  typedef logic [4:0] ActiveListIndex;
  typedef enum logic [1:0] {AL_IDLE, AL_WALK, AL_DONE} ActiveListState;
  localparam int ACTIVE_LIST_DEPTH = 32;
endpackage

// File: rtl/active_list.sv
// active_list: in-order retirement buffer with flush walk-back for rename recovery
// Ports: alloc_* allocate at tail (alloc_ready/alloc_index report availability and slot),
// wb_* mark an entry done, commit_* retire the head and free its old tag,
// flush_req/flush_instr_id squash younger entries, restore_* replay old mappings
// youngest-first, flushing/end_flush report the walk, count is occupancy.
module active_list
  import mips_core_pkg::*;
#(
  parameter int DEPTH = ACTIVE_LIST_DEPTH,
  parameter int PHYS_REGS = 64,
  parameter int ID_WIDTH = 32,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic                alloc_uses_rw,
  input  logic [4:0]          alloc_arch_rw,
  input  logic [PW-1:0]       alloc_new_phys,
  input  logic [PW-1:0]       alloc_old_phys,
  input  logic [ID_WIDTH-1:0] alloc_instr_id,
  output logic                alloc_ready,
  output logic [IW-1:0]       alloc_index,
  input  logic                wb_valid,
  input  logic [IW-1:0]       wb_index,
  input  logic                flush_req,
  input  logic [ID_WIDTH-1:0] flush_instr_id,
  output logic                commit_valid,
  output logic                commit_free_valid,
  output logic [PW-1:0]       commit_old_phys,
  output logic                restore_valid,
  output logic [4:0]          restore_arch,
  output logic [PW-1:0]       restore_phys,
  output logic [PW-1:0]       restore_free_phys,
  output logic                flushing,
  output logic                end_flush,
  output logic [IW:0]         count
);
  ActiveListState r_state;
  logic [IW-1:0] r_head, r_tail;
  logic [IW:0] r_count;
  logic [ID_WIDTH-1:0] r_fid;
  logic [DEPTH-1:0] r_done;
  logic r_uses [DEPTH];
  logic [4:0] r_arch [DEPTH];
  logic [PW-1:0] r_new [DEPTH];
  logic [PW-1:0] r_old [DEPTH];
  logic [ID_WIDTH-1:0] r_id [DEPTH];
  logic w_idle, w_ready, w_alloc, w_commit, w_squash, w_wb_occ;
  logic [IW-1:0] w_e, w_off;
  logic [ID_WIDTH-1:0] w_fid_min;
  always_comb begin
    w_idle = r_state == AL_IDLE;
    w_e = r_tail - 1'b1;
    w_off = wb_index - r_head;
    // occupancy MSB set means exactly DEPTH entries held
    w_ready = !r_count[IW] && w_idle && !flush_req;
    w_alloc = alloc_valid && w_ready;
    w_commit = w_idle && !flush_req && (r_count != '0) && r_done[r_head];
    w_squash = (r_state == AL_WALK) && (r_count != '0) && (r_id[w_e] > r_fid);
    // offset from head below occupancy means the slot holds a live entry
    w_wb_occ = {1'b0, w_off} < r_count;
    w_fid_min = flush_instr_id < r_fid ? flush_instr_id : r_fid;
  end
  assign alloc_ready = w_ready;
  assign alloc_index = r_tail;
  assign commit_valid = w_commit;
  assign commit_free_valid = w_commit && r_uses[r_head];
  assign commit_old_phys = w_commit ? r_old[r_head] : '0;
  assign restore_valid = w_squash && r_uses[w_e];
  assign restore_arch = restore_valid ? r_arch[w_e] : '0;
  assign restore_phys = restore_valid ? r_old[w_e] : '0;
  assign restore_free_phys = restore_valid ? r_new[w_e] : '0;
  assign flushing = r_state == AL_WALK;
  // a new flush arriving in DONE restarts the walk instead of completing
  assign end_flush = (r_state == AL_DONE) && !flush_req;
  assign count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= AL_IDLE;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_fid <= '0;
    end else begin
      r_head <= w_commit ? r_head + 1'b1 : r_head;
      r_tail <= w_alloc ? r_tail + 1'b1 : w_squash ? w_e : r_tail;
      r_count <= r_count + {{IW{1'b0}}, w_alloc} - {{IW{1'b0}}, w_commit | w_squash};
      // a flush during the walk may lower fid, so keep walking rather than finish
      r_state <= w_idle ? (flush_req ? AL_WALK : AL_IDLE)
               : (r_state == AL_WALK) ? ((w_squash || flush_req) ? AL_WALK : AL_DONE)
               : (flush_req ? AL_WALK : AL_IDLE);
      r_fid <= flush_req ? (w_idle ? flush_instr_id : w_fid_min) : r_fid;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= '0;
    end else begin
      if (wb_valid && w_wb_occ) r_done[wb_index] <= 1'b1;
      if (w_commit) r_done[r_head] <= 1'b0;
      if (w_squash) r_done[w_e] <= 1'b0;
      if (w_alloc) r_done[r_tail] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_uses[r_tail] <= alloc_uses_rw;
      r_arch[r_tail] <= alloc_arch_rw;
      r_new[r_tail] <= alloc_new_phys;
      r_old[r_tail] <= alloc_old_phys;
      r_id[r_tail] <= alloc_instr_id;
    end
  end
endmodule

// File: tb/tb_active_list.sv
// tb_active_list: randomized scoreboard bench for active_list against a queue-based model
module tb_active_list;
  logic clk = 1'b0, rst;
  logic alloc_valid, alloc_uses_rw, wb_valid, flush_req;
  logic [4:0] alloc_arch_rw, wb_index;
  logic [5:0] alloc_new_phys, alloc_old_phys;
  logic [31:0] alloc_instr_id, flush_instr_id;
  logic alloc_ready, commit_valid, commit_free_valid, restore_valid, flushing, end_flush;
  logic [4:0] alloc_index, restore_arch;
  logic [5:0] commit_old_phys, restore_phys, restore_free_phys, count;
  always #5 clk = ~clk;
  active_list dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_uses_rw(alloc_uses_rw), .alloc_arch_rw(alloc_arch_rw),
    .alloc_new_phys(alloc_new_phys), .alloc_old_phys(alloc_old_phys), .alloc_instr_id(alloc_instr_id),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .wb_valid(wb_valid), .wb_index(wb_index),
    .flush_req(flush_req), .flush_instr_id(flush_instr_id),
    .commit_valid(commit_valid), .commit_free_valid(commit_free_valid), .commit_old_phys(commit_old_phys),
    .restore_valid(restore_valid), .restore_arch(restore_arch), .restore_phys(restore_phys),
    .restore_free_phys(restore_free_phys), .flushing(flushing), .end_flush(end_flush), .count(count)
  );
  typedef struct {int unsigned id; bit uses; int arch; int newp; int oldp; bit done; int idx;} ent_t;
  typedef struct {int kind; int a; int b; int c;} ev_t;
  ent_t q[$];
  ev_t sb[$];
  int m_mode, m_tail;
  int unsigned m_fid, next_id;
  bit e_cv, e_rv, e_ef, e_fl, e_rdy;
  int e_cnt, e_idx;
  int n_cmp = 0, n_bad = 0;
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction
  always @(negedge clk) begin
    ev_t ev;
    check("commit_valid", commit_valid, e_cv);
    check("restore_valid", restore_valid, e_rv);
    check("end_flush", end_flush, e_ef);
    check("flushing", flushing, e_fl);
    check("count", count, e_cnt);
    check("alloc_ready", alloc_ready, e_rdy);
    check("alloc_index", alloc_index, e_idx);
    if (!rst && (commit_valid || restore_valid || end_flush)) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        ev = sb.pop_front();
        if (commit_valid) begin
          check("commit_kind", ev.kind, 0);
          check("commit_free_valid", commit_free_valid, ev.a);
          check("commit_old_phys", commit_old_phys, ev.b);
        end else if (restore_valid) begin
          check("restore_kind", ev.kind, 1);
          check("restore_arch", restore_arch, ev.a);
          check("restore_phys", restore_phys, ev.b);
          check("restore_free_phys", restore_free_phys, ev.c);
        end else check("end_flush_kind", ev.kind, 2);
      end
    end
  end
  task automatic step(bit av, bit uses, int arch, int newp, int oldp, bit wbv, int wbi, bit fr, int unsigned fid);
    bit rdy, cm, sq;
    int sz;
    alloc_valid = av; alloc_uses_rw = uses; alloc_arch_rw = 5'(arch);
    alloc_new_phys = 6'(newp); alloc_old_phys = 6'(oldp); alloc_instr_id = next_id;
    wb_valid = wbv; wb_index = 5'(wbi); flush_req = fr; flush_instr_id = fid;
    sz = q.size();
    rdy = sz < 32 && m_mode == 0 && !fr;
    cm = 0;
    sq = 0;
    if (m_mode == 0 && !fr && sz > 0) cm = q[0].done;
    if (m_mode == 1 && sz > 0) sq = q[sz-1].id > m_fid;
    e_rdy = rdy; e_cv = cm; e_rv = sq && q[sz-1].uses;
    e_ef = m_mode == 2 && !fr; e_fl = m_mode == 1; e_cnt = sz; e_idx = m_tail;
    if (cm) sb.push_back('{kind: 0, a: int'(q[0].uses), b: q[0].oldp, c: 0});
    if (e_rv) sb.push_back('{kind: 1, a: q[sz-1].arch, b: q[sz-1].oldp, c: q[sz-1].newp});
    if (e_ef) sb.push_back('{kind: 2, a: 0, b: 0, c: 0});
    if (wbv) foreach (q[i]) if (q[i].idx == wbi) q[i].done = 1;
    if (cm) void'(q.pop_front());
    if (sq) begin
      void'(q.pop_back());
      m_tail = (m_tail + 31) % 32;
    end
    if (av && rdy) begin
      q.push_back('{id: next_id, uses: uses, arch: arch, newp: newp, oldp: oldp, done: 0, idx: m_tail});
      m_tail = (m_tail + 1) % 32;
      next_id++;
    end
    if (m_mode == 0) begin
      if (fr) begin m_mode = 1; m_fid = fid; end
    end else if (m_mode == 1) begin
      if (fr && fid < m_fid) m_fid = fid;
      if (!sq && !fr) m_mode = 2;
    end else begin
      if (fr) begin
        m_mode = 1;
        if (fid < m_fid) m_fid = fid;
      end else m_mode = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    check("sb_drained", sb.size(), 0);
    rst = 1'b1;
    alloc_valid = 0; alloc_uses_rw = 0; alloc_arch_rw = 0; alloc_new_phys = 0; alloc_old_phys = 0;
    alloc_instr_id = 0; wb_valid = 0; wb_index = 0; flush_req = 0; flush_instr_id = 0;
    q.delete(); sb.delete();
    m_mode = 0; m_tail = 0; m_fid = 0; next_id = 0;
    e_cv = 0; e_rv = 0; e_ef = 0; e_fl = 0; e_rdy = 1; e_cnt = 0; e_idx = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic alloc(bit uses, int arch, int newp, int oldp);
    step(1, uses, arch, newp, oldp, 0, 0, 0, 0);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wb(int idx);
    step(0, 0, 0, 0, 0, 1, idx, 0, 0);
  endtask
  task automatic flush(int unsigned fid);
    step(0, 0, 0, 0, 0, 0, 0, 1, fid);
  endtask
  initial begin
    int wbi;
    int unsigned d;
    do_reset();
    idle(1);
    for (int i = 0; i < 32; i++) alloc(i % 2, i, 32 + i, i);
    check("full_count", count, 32);
    check("full_ready", alloc_ready, 0);
    alloc(1, 1, 1, 1);
    check("full_ignored_count", count, 32);
    check("full_ignored_tail", alloc_index, 0);
    for (int i = 0; i < 32; i++) wb(i);
    idle(3);
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1, i, 50 + i, 10 + i);
    wb(2);
    wb(1);
    wb(0);
    idle(4);
    check("partial_commit_count", count, 1);
    do_reset();
    next_id = 10;
    for (int i = 0; i < 6; i++) alloc(1, i, 40 + i, 20 + i);
    flush(12);
    idle(6);
    check("flush_count", count, 3);
    flush(100);
    idle(3);
    check("noop_flush_count", count, 3);
    do_reset();
    for (int i = 0; i < 30; i++) alloc(1, i, i, 63 - i);
    for (int i = 0; i < 30; i++) wb(i);
    idle(4);
    check("wrap_empty", count, 0);
    for (int i = 0; i < 10; i++) alloc(i % 3 != 0, i, 10 + i, 30 + i);
    check("wrap_tail", alloc_index, 8);
    for (int i = 0; i < 10; i++) wb((30 + i) % 32);
    idle(12);
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1, i, i, i);
    flush(0);
    idle(1);
    do_reset();
    check("rst_walk_count", count, 0);
    check("rst_walk_flushing", flushing, 0);
    check("rst_walk_ready", alloc_ready, 1);
    idle(6);
    for (int r = 0; r < 3000; r++) begin
      wbi = $urandom_range(0, 31);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wbi = q[$urandom_range(0, q.size() - 1)].idx;
      d = $urandom_range(0, 8);
      step($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 63),
           $urandom_range(0, 63), 1'($urandom), wbi, $urandom_range(0, 24) == 0,
           next_id > d ? next_id - d : 0);
    end
    idle(40);
    check("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
